// File: rtl/mult_seq_pkg.sv
// Shared definitions for the digit-serial multiplier: FSM states and
// the digit and partial-product widths of the 2x2 multiplier cell.
package mult_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIGIT_W = 2;
    localparam int PP_W    = 4;

endpackage

// File: rtl/mult2.sv
// 2x2 unsigned combinational multiplier cell. It yields a full 4-bit
// product (max 3*3 = 9), so nothing is truncated.
module mult2
    import mult_seq_pkg::*;
(
    input  logic [DIGIT_W-1:0] x,
    input  logic [DIGIT_W-1:0] y,
    output logic [PP_W-1:0]    pp
);

    // Zero-extend both digits so the product is formed at full width.
    always_comb begin
        pp = {{(PP_W-DIGIT_W){1'b0}}, x} * {{(PP_W-DIGIT_W){1'b0}}, y};
    end

endmodule

// File: rtl/mult_digit_serial.sv
// W x W unsigned multiplier that reuses one 2x2 cell over all D*D digit
// pairs. The inner index j walks the b digits and the outer index i walks
// the a digits. Each RUN cycle adds one shifted partial product to acc.
//
// Handshake rules:
//   - A transfer happens on a rising edge where valid and ready are both high.
//   - valid, once raised, holds with stable data until that transfer.
//   - ready is decoded from registered state only, never from inputs.
module mult_digit_serial
    import mult_seq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] p,
    output logic           busy
);

    localparam int D  = W / 2;
    localparam int IW = (D > 1) ? $clog2(D) : 1;
    localparam logic [IW-1:0] LAST = IW'(D - 1);

    state_t           state;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [2*W-1:0]   acc;
    logic [IW-1:0]    i;
    logic [IW-1:0]    j;

    logic [W-1:0]       a_sh;
    logic [W-1:0]       b_sh;
    logic [DIGIT_W-1:0] a_dig;
    logic [DIGIT_W-1:0] b_dig;
    logic [PP_W-1:0]    pp;
    logic [IW:0]        ij;
    logic [2*W-1:0]     pp_sh;

    // Digit muxes: shift the operand down by two bits per index and keep
    // the low digit. The shifter places pp at weight 4^(i+j). Its largest
    // shift is 2W-4, so the 4-bit pp always fits in 2W bits.
    always_comb begin
        a_sh  = a_q >> {i, 1'b0};
        b_sh  = b_q >> {j, 1'b0};
        a_dig = a_sh[DIGIT_W-1:0];
        b_dig = b_sh[DIGIT_W-1:0];
        ij    = {1'b0, i} + {1'b0, j};
        pp_sh = {{(2*W-PP_W){1'b0}}, pp} << {ij, 1'b0};
    end

    mult2 u_cell (
        .x  (a_dig),
        .y  (b_dig),
        .pp (pp)
    );

    // p is the accumulator itself. It stays frozen in DONE and after the
    // return to IDLE, until the next accept clears acc.
    assign p = acc;

    // Control FSM, operand registers, digit indices and accumulator.
    // in_ready, busy and out_valid are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
            i         <= '0;
            j         <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= a;
                        b_q      <= b;
                        acc      <= '0;
                        i        <= '0;
                        j        <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    acc <= acc + pp_sh;
                    if (j == LAST) begin
                        j <= '0;
                        if (i == LAST) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            i <= i + 1'b1;
                        end
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_digit_serial.sv
// Bench for mult_digit_serial. It drives a W=8 instance through a vector
// table, random operands, backpressure and a mid-run reset. It drives a
// W=4 instance back to back with out_ready tied high. Expected products
// come from constants or from plain a*b arithmetic.
module tb_mult_digit_serial;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- W=8 instance ----------------
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [7:0]  a, b;
    logic [15:0] p;

    mult_digit_serial #(.W(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    // ---------------- W=4 instance ----------------
    logic       in_valid4, in_ready4, out_valid4, out_ready4, busy4;
    logic [3:0] a4, b4;
    logic [7:0] p4;

    mult_digit_serial #(.W(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a         (a4),
        .b         (b4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .p         (p4),
        .busy      (busy4)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;

    logic [15:0] exp_q[$];
    logic [7:0]  exp_q4[$];
    int          acc_edge4[$];
    int          val_edge4[$];
    int          unexp4 = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // W=4 output monitor: with out_ready4 high each product is visible for one cycle.
    always @(negedge clk) begin
        if (rst_n && out_valid4 && out_ready4) begin
            if (exp_q4.size() == 0) begin
                unexp4++;
            end else begin
                chk("w4_p", p4, exp_q4.pop_front());
                val_edge4.push_back(cyc);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // One W=8 operation. Optionally zero a/b during RUN, hold out_ready low
    // for 'hold' DONE cycles, and present a pending in_valid while held.
    task automatic run_op8(input logic [7:0] aa, input logic [7:0] bb,
                           input logic [15:0] want, input int hold,
                           input bit scramble, input bit pend);
        int k;
        int nbusy;
        exp_q.push_back(want);
        @(negedge clk);
        a = aa; b = bb; in_valid = 1'b1; out_ready = 1'b0;
        chk("in_ready_idle", in_ready, 1);
        @(posedge clk);            // accept edge E0
        @(negedge clk);
        in_valid = 1'b0;
        if (scramble) begin a = '0; b = '0; end
        chk("in_ready_run", in_ready, 0);
        k = 0; nbusy = 0;
        while (!out_valid && k < 200) begin
            if (busy) nbusy++;
            k++;
            @(negedge clk);
        end
        chk("latency", k, 16);
        chk("busy_cycles", nbusy, 16);
        chk("p_done", p, exp_q[0]);
        if (pend) begin
            in_valid = 1'b1; a = 8'h11; b = 8'h22;
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_p", p, exp_q[0]);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_busy", busy, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);            // product handshake
        void'(exp_q.pop_front());
        @(negedge clk);
        out_ready = 1'b0;
        chk("valid_after_hs", out_valid, 0);
        chk("in_ready_after_hs", in_ready, 1);
        chk("busy_after_hs", busy, 0);
        chk("p_after_hs", p, want);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
        int          hold;
        bit          scramble;
        bit          pend;
    } vec_t;

    vec_t vecs[8];

    // ---------------- main test ----------------
    initial begin
        int waited;
        logic [7:0] ra, rb;
        logic [3:0] ra4, rb4;

        vecs[0] = '{8'hFF, 8'hFF, 16'hFE01, 0, 1'b0, 1'b0};
        vecs[1] = '{8'hB7, 8'h3C, 16'h2AE4, 0, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h5A, 16'h0000, 1, 1'b0, 1'b0};
        vecs[3] = '{8'h12, 8'h34, 16'h03A8, 0, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 8'hFF, 16'hFE01, 5, 1'b0, 1'b1};
        vecs[5] = '{8'h80, 8'h80, 16'h4000, 2, 1'b1, 1'b0};
        vecs[6] = '{8'h01, 8'hFF, 16'h00FF, 0, 1'b0, 1'b0};
        vecs[7] = '{8'hA5, 8'h01, 16'h00A5, 3, 1'b1, 1'b1};

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        in_valid4 = 1'b0; out_ready4 = 1'b1; a4 = '0; b4 = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_p", p, 0);
        chk("rst4_in_ready", in_ready4, 1);
        chk("rst4_busy", busy4, 0);
        chk("rst4_p", p4, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven vectors.
        for (int n = 0; n < 8; n++)
            run_op8(vecs[n].a, vecs[n].b, vecs[n].p, vecs[n].hold, vecs[n].scramble, vecs[n].pend);

        // Random operands against the arithmetic model.
        for (int n = 0; n < 20; n++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            run_op8(ra, rb, 16'(int'(ra) * int'(rb)), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset in RUN cycle 7: the in-flight result must vanish.
        @(negedge clk);
        a = 8'h77; b = 8'h99; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_p", p, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        waited = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid || busy || !in_ready) waited++;
        end
        chk("post_rst_quiet", waited, 0);
        chk("post_rst_p", p, 0);
        run_op8(8'h03, 8'h05, 16'h000F, 0, 1'b0, 1'b0);

        // W=4 back to back with out_ready4 high; in_valid4 stays asserted.
        for (int n = 0; n < 6; n++) begin
            ra4 = (n == 0) ? 4'hF : 4'($urandom_range(0, 15));
            rb4 = (n == 0) ? 4'hD : 4'($urandom_range(0, 15));
            a4 = ra4; b4 = rb4; in_valid4 = 1'b1;
            waited = 0;
            while (!in_ready4 && waited < 50) begin
                @(negedge clk);
                waited++;
            end
            if (waited >= 50) chk("w4_accept_timeout", waited, 0);
            acc_edge4.push_back(cyc + 1);
            if (n == 0) exp_q4.push_back(8'hC3);
            else        exp_q4.push_back(8'(int'(ra4) * int'(rb4)));
            @(negedge clk);
        end
        in_valid4 = 1'b0;
        waited = 0;
        while (exp_q4.size() != 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        chk("w4_drained", exp_q4.size(), 0);
        chk("w4_unexpected", unexp4, 0);
        chk("w4_count", val_edge4.size(), 6);
        if (val_edge4.size() == 6) begin
            for (int n = 0; n < 6; n++)
                chk("w4_latency", val_edge4[n] - acc_edge4[n], 4);
        end
        for (int n = 1; n < 6; n++)
            chk("w4_ii", acc_edge4[n] - acc_edge4[n-1], 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
